// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM read port, instruction handshake to decode, and PC redirect.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 14
) ();

  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              fetch_err;
  logic [31:0]       fetch_cnt;

  // Fetch stage side.
  modport master (
    output rom_addr,
    input  rom_data,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_err,
    output fetch_cnt
  );

  // ROM / consumer / redirect-source side.
  modport slave (
    input  rom_addr,
    output rom_data,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    output redirect_valid,
    output redirect_pc,
    input  fetch_err,
    input  fetch_cnt
  );

endinterface

// File: rtl/instr_fetch.sv
// Multicycle instruction fetch: owns the PC, reads a synchronous ROM with one-cycle
// latency, and hands the word plus its PC to decode over valid/ready.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    StReq,
    StCapt,
    StValid,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] cnt_q, cnt_d;

  // State registers; asynchronous reset restores the power-on values at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      cnt_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic: fetch sequencing first, then a redirect overrides PC and state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      StReq: begin
        state_d = StCapt;
      end
      StCapt: begin
        // A redirect squashes the word in flight, so do not even latch it.
        if (!bus.redirect_valid) begin
          instr_d    = bus.rom_data;
          instr_pc_d = pc_q;
        end
        state_d = StValid;
      end
      StValid: begin
        if (bus.instr_ready) begin
          pc_d    = pc_q + 32'd4;
          cnt_d   = cnt_q + 32'd1;
          state_d = StReq;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StReq;
      end
    endcase

    // The handshake count above survives a coincident redirect; only the PC step is dropped.
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      state_d = (bus.redirect_pc[1:0] == 2'b00) ? StReq : StErr;
    end
  end

  // Outputs come straight from registers; status flags decode the state flops.
  always_comb begin
    bus.rom_addr    = pc_q[ADDR_W-1:0];
    bus.instr_valid = (state_q == StValid);
    bus.fetch_err   = (state_q == StErr);
    bus.instr       = instr_q;
    bus.instr_pc    = instr_pc_q;
    bus.fetch_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch rules.
module tb_instr_fetch;

  localparam int unsigned AddrW    = 14;
  localparam int unsigned RomWords = 512;

  logic clk;
  logic rst_n;

  instr_fetch_if #(.ADDR_W(AddrW)) bus ();

  instr_fetch #(
    .RESET_PC(32'h0000_0000),
    .ADDR_W  (AddrW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks;
  int n_errors;

  logic [31:0] mem [RomWords];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents as seen at a full 32-bit PC; zero outside the populated range.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [11:0] idx;
    idx = addr[13:2];
    if (int'(idx) < RomWords) return mem[idx];
    return 32'h0;
  endfunction

  // Synchronous ROM: word appears one edge after the address.
  always @(posedge clk) begin
    bus.rom_data <= rom_word({18'h0, bus.rom_addr});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Model state for the random phase.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          m_age;
  logic        m_err;

  initial begin
    logic        m_valid;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        hs;

    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < RomWords; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_1097;
    mem[1] = 32'h26c0_8093;

    rst_n              = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_instr", bus.instr, 32'h0);
    check_eq("rst_instr_pc", bus.instr_pc, 32'h0);
    check_eq("rst_cnt", bus.fetch_cnt, 32'h0);
    check_eq("rst_err", 32'(bus.fetch_err), 32'd0);
    check_eq("rst_addr", 32'(bus.rom_addr), 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // First fetch: valid two edges after release.
    step();
    check_eq("lat_valid_lo", 32'(bus.instr_valid), 32'd0);
    step();
    check_eq("first_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("first_instr", bus.instr, 32'h0000_1097);
    check_eq("first_pc", bus.instr_pc, 32'h0);
    step();
    step();
    step();
    check_eq("second_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("second_instr", bus.instr, 32'h26c0_8093);
    check_eq("second_pc", bus.instr_pc, 32'h4);
    check_eq("cnt_one", bus.fetch_cnt, 32'd1);

    // Backpressure: everything holds for 5 cycles.
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_valid", 32'(bus.instr_valid), 32'd1);
      check_eq("bp_instr", bus.instr, 32'h26c0_8093);
      check_eq("bp_pc", bus.instr_pc, 32'h4);
      check_eq("bp_cnt", bus.fetch_cnt, 32'd1);
      check_eq("bp_addr", 32'(bus.rom_addr), 32'h4);
    end
    bus.instr_ready = 1'b1;
    step();
    check_eq("cnt_two", bus.fetch_cnt, 32'd2);
    check_eq("bp_release_addr", 32'(bus.rom_addr), 32'h8);

    // Redirect while in CAPT: the word for pc 8 is never presented.
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h248;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("capt_redir_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("capt_redir_addr", 32'(bus.rom_addr), 32'h248);
    step();
    check_eq("capt_redir_valid2", 32'(bus.instr_valid), 32'd0);
    step();
    check_eq("capt_redir_v", 32'(bus.instr_valid), 32'd1);
    check_eq("capt_redir_pc", bus.instr_pc, 32'h248);
    check_eq("capt_redir_instr", bus.instr, rom_word(32'h248));

    // Redirect coincident with a handshake.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("sim_cnt", bus.fetch_cnt, 32'd3);
    check_eq("sim_addr", 32'(bus.rom_addr), 32'h100);
    check_eq("sim_valid", 32'(bus.instr_valid), 32'd0);
    step();
    step();
    check_eq("sim_pc", bus.instr_pc, 32'h100);
    check_eq("sim_instr", bus.instr, rom_word(32'h100));

    // Misaligned redirect parks in the error state.
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    step();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_eq("err_flag", 32'(bus.fetch_err), 32'd1);
      check_eq("err_valid", 32'(bus.instr_valid), 32'd0);
      step();
    end
    check_eq("err_cnt", bus.fetch_cnt, 32'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h104;
    step();
    bus.redirect_valid = 1'b0;
    check_eq("err_clear", 32'(bus.fetch_err), 32'd0);
    step();
    step();
    check_eq("err_rec_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("err_rec_pc", bus.instr_pc, 32'h104);

    // Asynchronous reset during VALID, mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("mid_rst_instr", bus.instr, 32'h0);
    check_eq("mid_rst_cnt", bus.fetch_cnt, 32'h0);
    check_eq("mid_rst_addr", 32'(bus.rom_addr), 32'h0);
    step();
    rst_n = 1'b1;

    // PC wrap past the top of the address space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    step();
    step();
    check_eq("wrap_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("wrap_pc", bus.instr_pc, 32'hFFFF_FFFC);
    check_eq("wrap_instr", bus.instr, 32'h0);
    bus.instr_ready = 1'b1;
    step();
    check_eq("wrap_addr", 32'(bus.rom_addr), 32'h0);
    step();
    step();
    check_eq("wrap_next_pc", bus.instr_pc, 32'h0);
    check_eq("wrap_next_instr", bus.instr, 32'h0000_1097);
    bus.instr_ready = 1'b0;

    // Random traffic against the transaction model.
    do_reset();
    m_pc  = 32'h0;
    m_cnt = 32'h0;
    m_age = 0;
    m_err = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      m_valid = !m_err && (m_age >= 2);
      check_eq("rnd_valid", 32'(bus.instr_valid), 32'(m_valid));
      check_eq("rnd_err", 32'(bus.fetch_err), 32'(m_err));
      check_eq("rnd_cnt", bus.fetch_cnt, m_cnt);
      check_eq("rnd_addr", 32'(bus.rom_addr), {18'h0, m_pc[13:0]});
      if (m_valid) begin
        check_eq("rnd_pc", bus.instr_pc, m_pc);
        check_eq("rnd_instr", bus.instr, rom_word(m_pc));
      end
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      bus.instr_ready    = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      step();
      hs = m_valid && rdy;
      if (hs) begin
        m_cnt = m_cnt + 32'd1;
        m_pc  = m_pc + 32'd4;
        m_age = 0;
      end else if (m_age < 3) begin
        m_age++;
      end
      if (rv) begin
        m_pc  = rpc;
        m_err = (rpc[1:0] != 2'b00);
        m_age = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Multicycle instruction-fetch stage for the RISC-V core. It owns the program counter, drives the byte address into the synchronous instruction ROM, and captures the returned word after the ROM's one-cycle read latency. It presents the word with its PC to the decode/execute FSM over a valid/ready handshake, and accepts PC redirects from branches, jumps and traps.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- ADDR_W, 14: width of ROM byte address (rom_addr = pc[ADDR_W-1:0]).
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rom_addr  out  ADDR_W  byte address to ROM; ROM registers read data, so the word appears on rom_data one edge later.
- rom_data  in  32  ROM read data (ROM returns 0 beyond its populated range; passed through unmodified).
- instr_valid  out  1  instr/instr_pc hold a fetched instruction.
- instr_ready  in  1  consumer accepts instr this cycle.
- instr  out  32  fetched instruction word.
- instr_pc  out  32  PC of instr.
- redirect_valid  in  1  load new PC, squash in-flight fetch.
- redirect_pc  in  32  redirect target.
- fetch_err  out  1  misaligned target; fetch halted.
- fetch_cnt  out  32  count of accepted instructions; wraps at 2^32.

## Operation
- State machine states: REQ, CAPT, VALID, ERR. Reset state: REQ.
- REQ: rom_addr = pc[ADDR_W-1:0]. Next state: CAPT.
- CAPT: rom_data now holds the word for pc. Capture instr <= rom_data and instr_pc <= pc. Next state: VALID.
- VALID: instr_valid = 1; instr and instr_pc are stable.
  - If instr_ready: pc <= pc + 4 (32-bit, wraps), fetch_cnt <= fetch_cnt + 1, next state REQ.
  - Otherwise stay in VALID; outputs do not change.
- ERR: instr_valid = 0 and fetch_err = 1. Stay in ERR until a redirect arrives.
- Redirect, accepted in any state:
  - pc <= redirect_pc and instr_valid drops on the next edge.
  - Any word in flight in CAPT is discarded.
  - Next state is REQ if redirect_pc[1:0] == 0, else ERR.
  - fetch_err clears on an aligned redirect.
- Redirect and instr_ready in the same VALID cycle: the handshake completes, so fetch_cnt increments. The redirect then sets pc; the pc+4 increment is discarded.
- rom_addr is always pc[ADDR_W-1:0], including in ERR, where it is don't-care for the ROM.
- Reset values:
  - pc = RESET_PC; state REQ.
  - instr = 0, instr_pc = 0, fetch_cnt = 0.
  - instr_valid = 0, fetch_err = 0.
  - rom_addr = RESET_PC[ADDR_W-1:0].
- Reset asserted mid-operation immediately restores all reset values, irrespective of state. The held instruction is lost.
- If RESET_PC is misaligned, the block still starts in REQ; the misalignment check applies to redirects only.

## Timing
- Edge 0: address presented in REQ. Edge 1: ROM registers the word. Edge 2: instr captured. instr_valid is high from edge 2.
- Fetch latency: 2 cycles from entering REQ to instr_valid.
- Minimum issue interval: 3 cycles per instruction (REQ, CAPT, VALID with ready=1).
- Redirect latency: redirect sampled at edge N. State is REQ with the new pc after edge N. Instruction at the target is valid after edge N+2.
- instr_valid never drops without a handshake or a redirect.
- instr and instr_pc are stable while instr_valid=1 and instr_ready=0.
- All outputs are registered except rom_addr, which is taken directly from the pc register.

## Test plan
- Reset, then ROM word 0x00001097 at 0x0 and 0x26c08093 at 0x4, instr_ready=1:
  - instr_valid rises 2 cycles after reset release, with instr=0x00001097 and instr_pc=0.
  - 3 cycles later instr=0x26c08093 and instr_pc=4.
  - fetch_cnt = 2 after both handshakes.
- Backpressure: instr_ready=0 for 5 cycles in VALID -> instr, instr_pc and fetch_cnt unchanged and rom_addr stays constant. Ready=1 -> pc advances by 4 on that edge.
- Redirect to 0x248 while in CAPT -> the captured word for the old pc is never presented. The next valid has instr_pc=0x248 and instr equal to the ROM word at 0x248.
- Simultaneous redirect (0x100) and instr_ready in VALID -> fetch_cnt increments by 1, and the next instr_pc=0x100, not old pc+4.
- Misaligned redirect to 0x102 -> fetch_err=1 and instr_valid stays 0 for 10 cycles. An aligned redirect to 0x104 then clears fetch_err, and instr_pc=0x104 appears 2 cycles later.
- Two edge cases:
  - Assert rst_n low during VALID -> instr_valid, instr and fetch_cnt go to 0 immediately, and pc returns to RESET_PC.
  - Run the PC to 0xFFFFFFFC -> it wraps to 0x0, and a fetch beyond the ROM range returns instr=0.
